// File: rtl/dm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_arbiter_pkg
//   Shared definitions for the data-memory arbiter:
//   - arbiter FSM state encoding
//   - requester identifiers used for round-robin bookkeeping
//   - DataMemory func3 size/sign encodings (loads and stores)
//   - helper to size the loader burst counter
// -----------------------------------------------------------------------------
package dm_arbiter_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_OWN_CORE = 2'd1;
  localparam logic [1:0] ST_OWN_LD   = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    OWN_CORE = ST_OWN_CORE,
    OWN_LD   = ST_OWN_LD
  } arb_state_e;

  // Which requester was granted most recently
  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_LD   = 1'b1
  } requester_e;

  // DataMemory func3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Burst counter width: clog2(burst_max), never narrower than one bit
  function automatic int burst_cnt_w(input int burst_max);
    return (burst_max < 2) ? 1 : $clog2(burst_max);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_arbiter_if
//   Bundles the two requester handshakes (core load/store path and loader)
//   and the DataMemory side of the arbiter.
//
//   Core side   : core_req/we/func3/addr/wdata in, core_gnt/rvalid/rdata/stall out
//   Loader side : ld_req/we/func3/addr/wdata/lock in, ld_gnt/rvalid/rdata out
//   Memory side : dm_addr/wdata/ctrl/wenable out, dm_rdata in (combinational)
//
//   modport slave  : the arbiter's view
//   modport master : the view of the requesters plus the memory model
// -----------------------------------------------------------------------------
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // core load/store port
  logic              core_req;
  logic              core_we;
  logic [2:0]        core_func3;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  // loader port
  logic              ld_req;
  logic              ld_we;
  logic [2:0]        ld_func3;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_lock;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  // DataMemory port
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [2:0]        dm_ctrl;
  logic              dm_wenable;
  logic [DATA_W-1:0] dm_rdata;

  modport slave (
    input  core_req, core_we, core_func3, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata, core_stall,
    input  ld_req, ld_we, ld_func3, ld_addr, ld_wdata, ld_lock,
    output ld_gnt, ld_rvalid, ld_rdata,
    output dm_addr, dm_wdata, dm_ctrl, dm_wenable,
    input  dm_rdata
  );

  modport master (
    output core_req, core_we, core_func3, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
    output ld_req, ld_we, ld_func3, ld_addr, ld_wdata, ld_lock,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  dm_addr, dm_wdata, dm_ctrl, dm_wenable,
    output dm_rdata
  );

endinterface

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//   Shares the single-cycle core's data memory between the core load/store
//   path and a program/data loader. One FSM (IDLE / OWN_CORE / OWN_LD) picks
//   the owner; the owner is granted combinationally in every cycle it keeps
//   requesting, so a steady owner gets one access per cycle. Load data is
//   captured into a per-requester register with a one-cycle rvalid pulse.
//
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : dm_arbiter_if.slave (core port, loader port, DataMemory port)
//
//   Parameters:
//     ADDR_W    : address width
//     DATA_W    : data width
//     BURST_MAX : max consecutive loader grants while ld_lock is held and
//                 the core is also waiting
// -----------------------------------------------------------------------------
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  localparam int CNT_W      = burst_cnt_w(BURST_MAX);
  localparam int BURST_LAST = BURST_MAX - 1;

  arb_state_e        state_q, state_d;
  requester_e        last_q, last_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

  logic              core_gnt;
  logic              ld_gnt;

  logic              core_rvalid_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic              ld_rvalid_q;
  logic [DATA_W-1:0] ld_rdata_q;

  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [2:0]        dm_ctrl;
  logic              dm_wenable;

  // Grants are a pure function of ownership and the live request, so a
  // requester that drops req never gets an access.
  assign core_gnt = (state_q == OWN_CORE) && bus.core_req;
  assign ld_gnt   = (state_q == OWN_LD)   && bus.ld_req;

  // Memory mux: the granted owner drives the memory, otherwise all zero
  always_comb begin
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_ctrl    = '0;
    dm_wenable = 1'b0;
    if (core_gnt) begin
      dm_addr    = bus.core_addr;
      dm_wdata   = bus.core_wdata;
      dm_ctrl    = bus.core_func3;
      dm_wenable = bus.core_we;
    end else if (ld_gnt) begin
      dm_addr    = bus.ld_addr;
      dm_wdata   = bus.ld_wdata;
      dm_ctrl    = bus.ld_func3;
      dm_wenable = bus.ld_we;
    end
  end

  // Next-state decision
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;

    if (core_gnt) begin
      last_d = REQ_CORE;
    end else if (ld_gnt) begin
      last_d = REQ_LD;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.core_req && bus.ld_req) begin
          // tie: whoever was not served last goes first
          state_d = (last_q == REQ_LD) ? OWN_CORE : OWN_LD;
        end else if (bus.core_req) begin
          state_d = OWN_CORE;
        end else if (bus.ld_req) begin
          state_d = OWN_LD;
        end
      end
      OWN_CORE: begin
        if (bus.ld_req) begin
          state_d = OWN_LD;
        end else if (!bus.core_req) begin
          state_d = IDLE;
        end
      end
      OWN_LD: begin
        // A locked loader keeps ownership for up to BURST_MAX grants even
        // with the core waiting; once the budget is spent, a waiting core wins.
        if (bus.ld_lock && bus.ld_req && (int'(burst_cnt_q) < BURST_LAST)) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else if (bus.core_req) begin
          state_d = OWN_CORE;
        end else if (!bus.ld_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (core_gnt || ((state_q == OWN_LD) && (state_d != OWN_LD))) begin
      burst_cnt_d = '0;
    end
  end

  // Registered state, rvalid pulses and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_q        <= REQ_LD;
      burst_cnt_q   <= '0;
      core_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      ld_rvalid_q   <= 1'b0;
      ld_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      burst_cnt_q   <= burst_cnt_d;
      core_rvalid_q <= core_gnt && !bus.core_we;
      ld_rvalid_q   <= ld_gnt && !bus.ld_we;
      if (core_gnt && !bus.core_we) begin
        core_rdata_q <= bus.dm_rdata;
      end
      if (ld_gnt && !bus.ld_we) begin
        ld_rdata_q <= bus.dm_rdata;
      end
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.core_stall  = bus.core_req && !core_gnt;

  assign bus.ld_gnt      = ld_gnt;
  assign bus.ld_rvalid   = ld_rvalid_q;
  assign bus.ld_rdata    = ld_rdata_q;

  assign bus.dm_addr     = dm_addr;
  assign bus.dm_wdata    = dm_wdata;
  assign bus.dm_ctrl     = dm_ctrl;
  assign bus.dm_wenable  = dm_wenable;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//   Directed bench for dm_arbiter with a small word-addressed memory model
//   behind the dm_* port. Inputs change 1 time unit after the rising edge;
//   outputs are sampled 2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BURST_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  logic [31:0] mem [0:63];

  int checks   = 0;
  int failures = 0;

  dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dm_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at the edge ending a wenable cycle
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h1111_1111;
      mem[8]  <= 32'h1234_5678;
      mem[9]  <= 32'hCAFE_F00D;
      mem[10] <= 32'h0BAD_F00D;
    end else if (bus.dm_wenable) begin
      mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
    end
  end

  assign bus.dm_rdata = mem[bus.dm_addr[7:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_func3 = 3'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.ld_req     = 1'b0;
    bus.ld_we      = 1'b0;
    bus.ld_func3   = 3'b0;
    bus.ld_addr    = '0;
    bus.ld_wdata   = '0;
    bus.ld_lock    = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] flags;
    // values while held in reset
    flags = {bus.core_gnt, bus.ld_gnt, bus.dm_wenable, bus.core_rvalid, bus.ld_rvalid};
    checks++;
    if (flags !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b", flags, 5'b0);
    end
    checks++;
    if (bus.core_rdata !== 32'h0 || bus.ld_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.core_rdata, bus.ld_rdata);
    end
    reset = 1'b1;
    step();
    // store 0xDEADBEEF to 0x10 and pull reset in the middle of its grant
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_func3 = F3_SW;
    bus.core_addr  = 32'h10;
    bus.core_wdata = 32'hDEAD_BEEF;
    step();
    checks++;
    if (bus.core_gnt !== 1'b1 || bus.dm_wenable !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_grant got=%b%b exp=11", bus.core_gnt, bus.dm_wenable);
    end
    reset = 1'b0;
    #1;
    flags = {bus.core_gnt, bus.ld_gnt, bus.dm_wenable, bus.core_rvalid, bus.ld_rvalid};
    checks++;
    if (flags !== 5'b0) begin
      failures++;
      $display("FAIL reset_midgrant_flags got=%b exp=%b", flags, 5'b0);
    end
    checks++;
    if (bus.dm_addr !== 32'h0 || bus.dm_wdata !== 32'h0 || bus.dm_ctrl !== 3'b0) begin
      failures++;
      $display("FAIL reset_midgrant_dm got=%h/%h/%h exp=0/0/0", bus.dm_addr, bus.dm_wdata, bus.dm_ctrl);
    end
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (mem[4] !== 32'h1111_1111) begin
      failures++;
      $display("FAIL reset_no_commit got=%h exp=%h", mem[4], 32'h1111_1111);
    end
  endtask

  task automatic test_single_load();
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b0;
    bus.core_func3 = F3_LW;
    bus.core_addr  = 32'h20;
    #1;
    checks++;
    if (bus.core_gnt !== 1'b0 || bus.core_stall !== 1'b1) begin
      failures++;
      $display("FAIL load_c1 gnt/stall got=%b%b exp=01", bus.core_gnt, bus.core_stall);
    end
    step();
    #1;
    checks++;
    if (bus.core_gnt !== 1'b1 || bus.core_stall !== 1'b0 || bus.core_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL load_c2 gnt/stall/rvalid got=%b%b%b exp=100", bus.core_gnt, bus.core_stall, bus.core_rvalid);
    end
    checks++;
    if (bus.dm_addr !== 32'h20 || bus.dm_ctrl !== F3_LW || bus.dm_wenable !== 1'b0) begin
      failures++;
      $display("FAIL load_c2 dm got=%h/%h/%b exp=20/%h/0", bus.dm_addr, bus.dm_ctrl, bus.dm_wenable, F3_LW);
    end
    step();
    bus.core_req = 1'b0;
    #1;
    checks++;
    if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL load_c3 rvalid/rdata got=%b/%h exp=1/12345678", bus.core_rvalid, bus.core_rdata);
    end
    checks++;
    if (bus.core_gnt !== 1'b0 || bus.core_stall !== 1'b0) begin
      failures++;
      $display("FAIL load_c3 gnt/stall got=%b%b exp=00", bus.core_gnt, bus.core_stall);
    end
    step();
    #1;
    checks++;
    if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL load_c4 hold got=%b/%h exp=0/12345678", bus.core_rvalid, bus.core_rdata);
    end
    step();
  endtask

  task automatic test_simultaneous();
    // fresh reset so the core wins the first tie
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b0;
    bus.core_func3 = F3_LW;
    bus.core_addr  = 32'h20;
    bus.ld_req     = 1'b1;
    bus.ld_we      = 1'b0;
    bus.ld_func3   = F3_LW;
    bus.ld_addr    = 32'h24;
    #1;
    checks++;
    if (bus.core_gnt !== 1'b0 || bus.ld_gnt !== 1'b0) begin
      failures++;
      $display("FAIL simul_c1 gnt got=%b%b exp=00", bus.core_gnt, bus.ld_gnt);
    end
    step();
    #1;
    checks++;
    if (bus.core_gnt !== 1'b1 || bus.ld_gnt !== 1'b0 || bus.dm_addr !== 32'h20) begin
      failures++;
      $display("FAIL simul_c2 got=%b%b/%h exp=10/20", bus.core_gnt, bus.ld_gnt, bus.dm_addr);
    end
    step();
    bus.core_req = 1'b0;
    #1;
    checks++;
    if (bus.core_gnt !== 1'b0 || bus.ld_gnt !== 1'b1 || bus.dm_addr !== 32'h24) begin
      failures++;
      $display("FAIL simul_c3 got=%b%b/%h exp=01/24", bus.core_gnt, bus.ld_gnt, bus.dm_addr);
    end
    checks++;
    if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'h1234_5678 || bus.ld_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL simul_c3 rvalid got=%b/%h/%b exp=1/12345678/0", bus.core_rvalid, bus.core_rdata, bus.ld_rvalid);
    end
    step();
    bus.ld_req = 1'b0;
    #1;
    checks++;
    if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== 32'hCAFE_F00D || bus.core_rvalid !== 1'b0 || bus.ld_gnt !== 1'b0) begin
      failures++;
      $display("FAIL simul_c4 got=%b/%h/%b/%b exp=1/cafef00d/0/0", bus.ld_rvalid, bus.ld_rdata, bus.core_rvalid, bus.ld_gnt);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp_d [3];
    addrs = '{32'h20, 32'h24, 32'h28};
    exp_d = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_F00D};
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b0;
    bus.core_func3 = F3_LW;
    bus.core_addr  = addrs[0];
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus.core_addr = addrs[i];
      else bus.core_req = 1'b0;
      #1;
      checks++;
      if (bus.core_gnt !== (i < 3)) begin
        failures++;
        $display("FAIL b2b_gnt[%0d] got=%b exp=%b", i, bus.core_gnt, (i < 3));
      end
      if (i > 0) begin
        checks++;
        if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== exp_d[i-1]) begin
          failures++;
          $display("FAIL b2b_rdata[%0d] got=%b/%h exp=1/%h", i, bus.core_rvalid, bus.core_rdata, exp_d[i-1]);
        end
      end
      step();
    end
    #1;
    checks++;
    if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL b2b_end got=%b/%h exp=0/0badf00d", bus.core_rvalid, bus.core_rdata);
    end
    step();
  endtask

  task automatic test_fairness();
    logic exp_ld;
    // core was served last, so the loader takes the first tie
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b0;
    bus.core_func3 = F3_LW;
    bus.core_addr  = 32'h20;
    bus.ld_req     = 1'b1;
    bus.ld_we      = 1'b0;
    bus.ld_func3   = F3_LW;
    bus.ld_addr    = 32'h24;
    bus.ld_lock    = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_ld = ((k % 2) == 0);
      checks++;
      if (bus.ld_gnt !== exp_ld || bus.core_gnt !== !exp_ld || bus.core_stall !== exp_ld) begin
        failures++;
        $display("FAIL fair[%0d] ld/core/stall got=%b%b%b exp=%b%b%b", k, bus.ld_gnt, bus.core_gnt,
                 bus.core_stall, exp_ld, !exp_ld, exp_ld);
      end
      step();
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_locked_burst();
    logic exp_core;
    bus.ld_req   = 1'b1;
    bus.ld_lock  = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_func3 = F3_SW;
    bus.ld_addr  = 32'h30;
    bus.ld_wdata = 32'hA0;
    step();
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b0;
    bus.core_func3 = F3_LW;
    bus.core_addr  = 32'h20;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_core = (k == BURST_MAX);
      checks++;
      if (bus.core_gnt !== exp_core || bus.ld_gnt !== !exp_core) begin
        failures++;
        $display("FAIL burst[%0d] core/ld got=%b%b exp=%b%b", k, bus.core_gnt, bus.ld_gnt, exp_core, !exp_core);
      end
      if (k == 5) begin
        checks++;
        if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'h1234_5678) begin
          failures++;
          $display("FAIL burst_core_load got=%b/%h exp=1/12345678", bus.core_rvalid, bus.core_rdata);
        end
      end
      step();
      if (exp_core) begin
        bus.core_req = 1'b0;
      end else begin
        bus.ld_addr  = bus.ld_addr + 32'd4;
        bus.ld_wdata = bus.ld_wdata + 32'd1;
      end
    end
    idle_inputs();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem[12+i] !== 32'hA0 + i) begin
        failures++;
        $display("FAIL burst_mem[%0d] got=%h exp=%h", 12 + i, mem[12+i], 32'hA0 + i);
      end
    end
    checks++;
    if (mem[17] !== 32'h0) begin
      failures++;
      $display("FAIL burst_mem_extra got=%h exp=0", mem[17]);
    end
  endtask

  task automatic test_withdrawal();
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_func3 = F3_SW;
    bus.ld_addr  = 32'h50;
    bus.ld_wdata = 32'h5555_5555;
    #1;
    checks++;
    if (bus.ld_gnt !== 1'b0) begin
      failures++;
      $display("FAIL wd_c1 gnt got=%b exp=0", bus.ld_gnt);
    end
    step();
    bus.ld_req = 1'b0;
    #1;
    checks++;
    if (bus.ld_gnt !== 1'b0 || bus.dm_wenable !== 1'b0 || bus.dm_addr !== 32'h0) begin
      failures++;
      $display("FAIL wd_c2 gnt/we/addr got=%b%b/%h exp=00/0", bus.ld_gnt, bus.dm_wenable, bus.dm_addr);
    end
    step();
    // a fresh request must wait a cycle, which only happens from IDLE
    bus.ld_req = 1'b1;
    bus.ld_we  = 1'b0;
    bus.ld_func3 = F3_LW;
    bus.ld_addr = 32'h24;
    #1;
    checks++;
    if (bus.ld_rvalid !== 1'b0 || bus.ld_gnt !== 1'b0) begin
      failures++;
      $display("FAIL wd_c3 rvalid/gnt got=%b%b exp=00", bus.ld_rvalid, bus.ld_gnt);
    end
    step();
    #1;
    checks++;
    if (bus.ld_gnt !== 1'b1) begin
      failures++;
      $display("FAIL wd_c4 gnt got=%b exp=1", bus.ld_gnt);
    end
    step();
    bus.ld_req = 1'b0;
    #1;
    checks++;
    if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL wd_c5 got=%b/%h exp=1/cafef00d", bus.ld_rvalid, bus.ld_rdata);
    end
    checks++;
    if (mem[20] !== 32'h0) begin
      failures++;
      $display("FAIL wd_no_write got=%h exp=0", mem[20]);
    end
    step();
  endtask

  initial begin
    reset    = 1'b0;
    mem_init = 1'b1;
    idle_inputs();
    step();
    step();
    mem_init = 1'b0;
    test_reset();
    test_single_load();
    test_simultaneous();
    test_back_to_back();
    test_fairness();
    test_locked_burst();
    test_withdrawal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
